// File: rtl/pool_requant_fifo.sv
// Requantizes max-pool results to 8-bit pixels, tags row ends and buffers them in a
// first-word-fall-through FIFO with row/frame tracking on the drain side.
module pool_requant_fifo #(
    parameter int IN_W    = 15,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 7,
    parameter int DEPTH   = 16,
    parameter int ROW_LEN = 12,
    parameter int ROWS    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IN_W:0] ROUND = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [IN_W:0] QMAX  = (IN_W+1)'((1 << OUT_W) - 1);

    logic [OUT_W:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_r;
    logic [CW-1:0]    col;
    logic [CW-1:0]    pop_col;
    logic [RW-1:0]    pop_row;
    logic             overflow_r;
    logic             frame_done_r;

    logic [IN_W:0]    sum;
    logic [IN_W:0]    shifted;
    logic [OUT_W-1:0] q;
    logic [OUT_W:0]   head;
    logic             push;
    logic             pop;
    logic             last_flag;
    logic             frame_end;

    // Round half up in IN_W+1 bits so the rounding carry is never lost, then saturate.
    always_comb begin
        sum     = {1'b0, in_data} + ROUND;
        shifted = sum >> SHIFT;
        q       = (shifted > QMAX) ? '1 : shifted[OUT_W-1:0];
    end

    always_comb begin
        head       = mem[rd_ptr];
        out_data   = head[OUT_W-1:0];
        out_last   = head[OUT_W];
        out_valid  = (count_r != '0);
        full       = (count_r == (AW+1)'(DEPTH));
        push       = in_valid && !full;
        pop        = out_valid && out_ready;
        last_flag  = (col == CW'(ROW_LEN - 1));
        frame_end  = pop && out_last && (pop_row == RW'(ROWS - 1));
        count      = count_r;
        overflow   = overflow_r;
        frame_done = frame_done_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_r      <= '0;
            col          <= '0;
            pop_col      <= '0;
            pop_row      <= '0;
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {last_flag, q};
                wr_ptr      <= wr_ptr + 1'b1;
                col         <= last_flag ? '0 : col + 1'b1;
            end
            if (in_valid && full) begin
                overflow_r <= 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pop_col <= out_last ? '0 : pop_col + 1'b1;
                if (out_last) begin
                    pop_row <= (pop_row == RW'(ROWS - 1)) ? '0 : pop_row + 1'b1;
                end
            end
            frame_done_r <= frame_end;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_requant_fifo.sv
// Randomized bench for pool_requant_fifo: a queue-based reference model predicts every
// output each cycle, plus directed checks for requant values, fill/drop and frame tagging.
module tb_pool_requant_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [14:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       full;
    logic       overflow;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;

    int qd[$];
    bit ql[$];
    int mcol = 0;
    int prow = 0;
    bit movf = 1'b0;
    bit mfd  = 1'b0;
    int fd_seen = 0;
    int last_seen = 0;

    pool_requant_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .full       (full),
        .overflow   (overflow),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic int rq(input int d);
        int v;
        v = (d + 64) / 128;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic applyStimulus(input bit v, input int d, input bit rdy);
        bit do_pop;
        bit do_push;
        @(negedge clk);
        checkOutput("count", count, qd.size());
        checkOutput("out_valid", out_valid, qd.size() > 0);
        checkOutput("full", full, qd.size() == 16);
        checkOutput("overflow", overflow, movf);
        checkOutput("frame_done", frame_done, mfd);
        if (frame_done) fd_seen++;
        if (qd.size() > 0) begin
            checkOutput("head_data", out_data, qd[0]);
            checkOutput("head_last", out_last, ql[0]);
        end
        in_valid  = v;
        in_data   = d[14:0];
        out_ready = rdy;
        do_pop  = (qd.size() > 0) && rdy;
        do_push = v && (qd.size() < 16);
        if (v && !do_push) movf = 1'b1;
        mfd = 1'b0;
        if (do_pop) begin
            if (out_last) last_seen++;
            if (ql[0]) begin
                if (prow == 11) begin
                    prow = 0;
                    mfd  = 1'b1;
                end else begin
                    prow++;
                end
            end
            void'(qd.pop_front());
            void'(ql.pop_front());
        end
        if (do_push) begin
            qd.push_back(rq(d));
            ql.push_back(mcol == 11);
            mcol = (mcol + 1) % 12;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear without any clock edge.
    task automatic doReset();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        qd.delete();
        ql.delete();
        mcol = 0;
        prow = 0;
        movf = 1'b0;
        mfd  = 1'b0;
    endtask

    initial begin
        int rq_in[4]  = '{63, 64, 200, 32767};
        int rq_exp[4] = '{0, 1, 2, 255};

        #2;
        doReset();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, rq_in[i], 1'b1);
            checkOutput("rq_valid", out_valid, 1);
            checkOutput("rq_data", out_data, rq_exp[i]);
            applyStimulus(1'b0, 0, 1'b1);
        end

        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, k * 128, 1'b0);
        end
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 16);
        checkOutput("fill_no_ovf", overflow, 0);
        applyStimulus(1'b1, 17 * 128, 1'b0);
        checkOutput("drop_ovf", overflow, 1);
        checkOutput("drop_count", count, 16);
        for (int k = 1; k <= 16; k++) begin
            checkOutput("drain_data", out_data, k);
            applyStimulus(1'b0, 0, 1'b1);
            if (k == 1) checkOutput("drain_full_fall", full, 0);
        end
        checkOutput("drain_count", count, 0);

        doReset();
        applyStimulus(1'b1, 300, 1'b0);
        applyStimulus(1'b1, 1000, 1'b1);
        checkOutput("simul_count", count, 1);
        checkOutput("simul_head", out_data, 8);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, $urandom_range(0, 32767), 1'b0);
        end
        checkOutput("simul_full", full, 1);
        applyStimulus(1'b1, 5000, 1'b1);
        checkOutput("simul_drop_count", count, 15);
        checkOutput("simul_drop_ovf", overflow, 1);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 0, 1'b1);
        end
        checkOutput("pre_rst_count", count, 5);
        checkOutput("pre_rst_ovf", overflow, 1);
        doReset();

        fd_seen = 0;
        last_seen = 0;
        for (int i = 0; i < 144; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 32767), 1'b1);
            for (int j = 0; j < 3; j++) applyStimulus(1'b0, 0, 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("frame_fd_count", fd_seen, 1);
        checkOutput("frame_last_count", last_seen, 12);

        fd_seen = 0;
        last_seen = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 32767), 1'b1);
            for (int j = 0; j < 3; j++) applyStimulus(1'b0, 0, 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("row_fd_count", fd_seen, 0);
        checkOutput("row_last_count", last_seen, 1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(i % 2 == 0, $urandom_range(0, 32767), i % 2 == 1);
            checkOutput("bp_count_le2", count <= 2, 1);
        end
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 32767), i % 2 == 0);
        end
        for (int i = 0; i < 40 && qd.size() > 0; i++) begin
            applyStimulus(1'b0, 0, 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("end_empty", count, 0);
        checkOutput("end_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
